// File: rtl/hazard_ctrl.sv
// Hazard and resource controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use / branch-compare / mult-div stalls and the iterative mult/div occupancy counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemToRegE,
    input  logic       MemToRegM,
    input  logic       BranchD,
    input  logic       HiLoReadD,
    input  logic       MdIssueD,
    input  logic       MdStartE,
    input  logic       MdIsDivE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       MdBusy,
    output logic       MdDone
);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;
    logic             lwstall, branchstall, mdstall, stall;
    logic             md_busy;

    // A new start always restarts the count, even over a unit that is still busy.
    always_comb begin
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        if (MdStartE)
            md_cnt_d = MdIsDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CNT_W'(1);
        md_done_d = (md_cnt_q == CNT_W'(1)) && !MdStartE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wr_m,
                                           input logic [4:0] dst_m, input logic wr_w,
                                           input logic [4:0] dst_w);
        if (src != 5'd0 && wr_m && src == dst_m)      fwd_sel = 2'b10;
        else if (src != 5'd0 && wr_w && src == dst_w) fwd_sel = 2'b01;
        else                                          fwd_sel = 2'b00;
    endfunction

    assign md_busy     = (md_cnt_q != '0);
    assign lwstall     = MemToRegE && (RtE == RsD || RtE == RtD);
    assign branchstall = BranchD &&
                         ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                          (MemToRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    // MdStartE covers the cycle before the counter has loaded.
    assign mdstall     = (HiLoReadD || MdIssueD) && (md_busy || MdStartE);
    assign stall       = lwstall || branchstall || mdstall;

    // Everything is forced low while reset is held, whatever the pipeline presents.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        MdBusy    = 1'b0;
        MdDone    = 1'b0;
        if (rst) begin
            ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
            ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
            StallF    = stall;
            StallD    = stall;
            FlushE    = stall;
            MdBusy    = md_busy;
            MdDone    = md_done_q;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, mult/div stalls and reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic       BranchD, HiLoReadD, MdIssueD, MdStartE, MdIsDivE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdDone;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .HiLoReadD(HiLoReadD), .MdIssueD(MdIssueD),
        .MdStartE(MdStartE), .MdIsDivE(MdIsDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    task automatic clear_inputs();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemToRegE = 1'b0; MemToRegM = 1'b0; BranchD = 1'b0;
        HiLoReadD = 1'b0; MdIssueD = 1'b0; MdStartE = 1'b0; MdIsDivE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [2:0] stl;
        clear_inputs();
        rst = 1'b0;
        RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; HiLoReadD = 1'b1; MdStartE = 1'b1;
        #1;
        tests++; if (ForwardAE !== 2'b00) begin fails++; $display("FAIL reset_fwdAE got %b want 00", ForwardAE); end
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b000) begin fails++; $display("FAIL reset_stall got %b want 000", stl); end
        clear_inputs();
        step(); rst = 1'b1; step();
        // Divide start, then 15 more edges: counter at 17.
        MdStartE = 1'b1; MdIsDivE = 1'b1; step(); MdStartE = 1'b0;
        repeat (15) step();
        tests++; if (MdBusy !== 1'b1) begin fails++; $display("FAIL reset_middiv_busy got %b want 1", MdBusy); end
        RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; HiLoReadD = 1'b1;
        #2 rst = 1'b0; #1;
        tests++; if (MdBusy !== 1'b0) begin fails++; $display("FAIL reset_async_busy got %b want 0", MdBusy); end
        tests++; if (StallF !== 1'b0) begin fails++; $display("FAIL reset_async_stall got %b want 0", StallF); end
        tests++; if (ForwardAE !== 2'b00) begin fails++; $display("FAIL reset_async_fwd got %b want 00", ForwardAE); end
        clear_inputs();
        step(); rst = 1'b1; repeat (3) step();
        tests++; if (MdBusy !== 1'b0) begin fails++; $display("FAIL reset_after_busy got %b want 0", MdBusy); end
        tests++; if (MdDone !== 1'b0) begin fails++; $display("FAIL reset_after_done got %b want 0", MdDone); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; #1;
        tests++; if (ForwardAE !== 2'b10) begin fails++; $display("FAIL fwdAE_M got %b want 10", ForwardAE); end
        WriteRegM = 5'd6; #1;
        tests++; if (ForwardAE !== 2'b01) begin fails++; $display("FAIL fwdAE_W got %b want 01", ForwardAE); end
        RsE = 5'd0; WriteRegW = 5'd0; #1;
        tests++; if (ForwardAE !== 2'b00) begin fails++; $display("FAIL fwdAE_r0 got %b want 00", ForwardAE); end
        RtE = 5'd7; WriteRegM = 5'd7; RegWriteM = 1'b0; WriteRegW = 5'd7; #1;
        tests++; if (ForwardBE !== 2'b01) begin fails++; $display("FAIL fwdBE_W got %b want 01", ForwardBE); end
        RegWriteM = 1'b1; #1;
        tests++; if (ForwardBE !== 2'b10) begin fails++; $display("FAIL fwdBE_M got %b want 10", ForwardBE); end
        RegWriteW = 1'b0; RegWriteM = 1'b0; #1;
        tests++; if (ForwardBE !== 2'b00) begin fails++; $display("FAIL fwdBE_nowr got %b want 00", ForwardBE); end
        RsD = 5'd7; RtD = 5'd9; RegWriteM = 1'b1; #1;
        tests++; if ({ForwardAD, ForwardBD} !== 2'b10) begin fails++; $display("FAIL fwdD_rs got %b want 10", {ForwardAD, ForwardBD}); end
        RsD = 5'd0; RtD = 5'd0; WriteRegM = 5'd0; #1;
        tests++; if ({ForwardAD, ForwardBD} !== 2'b00) begin fails++; $display("FAIL fwdD_r0 got %b want 00", {ForwardAD, ForwardBD}); end
        RtD = 5'd4; WriteRegM = 5'd4; #1;
        tests++; if ({ForwardAD, ForwardBD} !== 2'b01) begin fails++; $display("FAIL fwdD_rt got %b want 01", {ForwardAD, ForwardBD}); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [2:0] stl;
        clear_inputs();
        MemToRegE = 1'b1; RtE = 5'd8; RsD = 5'd8; RtD = 5'd2; #1;
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b111) begin fails++; $display("FAIL lw_rs got %b want 111", stl); end
        RtE = 5'd9; #1;
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b000) begin fails++; $display("FAIL lw_nomatch got %b want 000", stl); end
        RtD = 5'd9; #1;
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b111) begin fails++; $display("FAIL lw_rt got %b want 111", stl); end
        MemToRegE = 1'b0; #1;
        tests++; if (StallF !== 1'b0) begin fails++; $display("FAIL lw_notload got %b want 0", StallF); end
        clear_inputs();
    endtask

    task automatic test_branch();
        logic [2:0] stl;
        clear_inputs();
        BranchD = 1'b1; RsD = 5'd3; RtD = 5'd1; RegWriteE = 1'b1; WriteRegE = 5'd3; #1;
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b111) begin fails++; $display("FAIL br_E got %b want 111", stl); end
        step();
        RegWriteE = 1'b0; WriteRegE = 5'd0; WriteRegM = 5'd3; RegWriteM = 1'b1; MemToRegM = 1'b0; #1;
        tests++; if (StallF !== 1'b0) begin fails++; $display("FAIL br_M_nostall got %b want 0", StallF); end
        tests++; if (ForwardAD !== 1'b1) begin fails++; $display("FAIL br_M_fwdAD got %b want 1", ForwardAD); end
        MemToRegM = 1'b1; #1;
        tests++; if (FlushE !== 1'b1) begin fails++; $display("FAIL br_loadM got %b want 1", FlushE); end
        // Two causes at once still show as one asserted stall.
        MemToRegE = 1'b1; RtE = 5'd3; #1;
        stl = {StallF, StallD, FlushE};
        tests++; if (stl !== 3'b111) begin fails++; $display("FAIL br_plus_lw got %b want 111", stl); end
        clear_inputs();
    endtask

    task automatic test_muldiv(input logic is_div, input int exp_stalls);
        int n = 0;
        int bad_done = 0;
        logic done_at_drop = 1'b0;
        clear_inputs();
        MdStartE = 1'b1; MdIsDivE = is_div; HiLoReadD = 1'b1; #1;
        for (int i = 0; i < 100; i++) begin
            if (!StallF) begin done_at_drop = MdDone; break; end
            n++;
            if (MdDone) bad_done++;
            step(); MdStartE = 1'b0; #1;
        end
        tests++; if (n != exp_stalls) begin fails++; $display("FAIL md_stalls div=%0b got %0d want %0d", is_div, n, exp_stalls); end
        tests++; if (done_at_drop !== 1'b1) begin fails++; $display("FAIL md_done_at_drop div=%0b got %b want 1", is_div, done_at_drop); end
        tests++; if (bad_done != 0) begin fails++; $display("FAIL md_early_done div=%0b got %0d want 0", is_div, bad_done); end
        HiLoReadD = 1'b0; step();
        tests++; if (MdDone !== 1'b0) begin fails++; $display("FAIL md_done_width div=%0b got %b want 0", is_div, MdDone); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic done_at_drop = 1'b0;
        clear_inputs();
        MdStartE = 1'b1; MdIsDivE = 1'b0; step(); MdStartE = 1'b0;
        MdIssueD = 1'b1; #1;
        for (int i = 0; i < 50; i++) begin
            if (!StallD) begin done_at_drop = MdDone; break; end
            n++;
            step();
        end
        tests++; if (n != 4) begin fails++; $display("FAIL b2b_held got %0d want 4", n); end
        tests++; if (done_at_drop !== 1'b1) begin fails++; $display("FAIL b2b_done got %b want 1", done_at_drop); end
        MdIssueD = 1'b0; step();
        MdStartE = 1'b1; MdIsDivE = 1'b0; step(); MdStartE = 1'b0;
        tests++; if ({MdBusy, MdDone} !== 2'b10) begin fails++; $display("FAIL b2b_reload got %b want 10", {MdBusy, MdDone}); end
        repeat (3) step();
        // Counter is at 1: a reload now must swallow the done pulse.
        MdStartE = 1'b1; step(); MdStartE = 1'b0;
        tests++; if ({MdBusy, MdDone} !== 2'b10) begin fails++; $display("FAIL b2b_restart got %b want 10", {MdBusy, MdDone}); end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (!MdBusy) break;
            n++;
            step();
        end
        tests++; if (n != 4) begin fails++; $display("FAIL b2b_restart_len got %0d want 4", n); end
        tests++; if (MdDone !== 1'b1) begin fails++; $display("FAIL b2b_final_done got %b want 1", MdDone); end
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_muldiv(1'b1, 33);
        test_muldiv(1'b0, 5);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and resource controller for the 5-stage MIPS core.
- Drives the execute-stage forwarding selects and the decode-stage branch-compare forwarding.
- Generates fetch/decode stalls and the execute flush for load-use, branch-compare and multi-cycle mult/div (HI/LO) conflicts.
- Holds a mult/div occupancy counter so only one iterative multiply or divide is in flight.

Parameters:
MULT_CYCLES, 4, cycles the mult unit is busy after issue (must be >=1)
DIV_CYCLES, 32, cycles the div unit is busy after issue (must be >=1)
CNT_W, 6, occupancy counter width (must hold max(MULT_CYCLES, DIV_CYCLES))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
RsD  input  5  decode source register rs
RtD  input  5  decode source register rt
RsE  input  5  execute source register rs
RtE  input  5  execute source register rt
WriteRegE  input  5  execute destination register
WriteRegM  input  5  memory destination register
WriteRegW  input  5  writeback destination register
RegWriteE  input  1  execute instruction writes the register file
RegWriteM  input  1  memory instruction writes the register file
RegWriteW  input  1  writeback instruction writes the register file
MemToRegE  input  1  execute instruction is a load
MemToRegM  input  1  memory instruction is a load
BranchD  input  1  decode instruction is beq/bne
HiLoReadD  input  1  decode instruction is mfhi/mflo
MdIssueD  input  1  decode instruction is mult/div
MdStartE  input  1  mult/div enters execute this cycle
MdIsDivE  input  1  qualifies MdStartE: 1=div, 0=mult
ForwardAE  output  2  srcA select: 00 regfile, 01 ResultW, 10 ALUOutM
ForwardBE  output  2  srcB select, same encoding
ForwardAD  output  1  decode rs compare operand from ALUOutM
ForwardBD  output  1  decode rt compare operand from ALUOutM
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
FlushE  output  1  clear ID/EX register (insert bubble)
MdBusy  output  1  mult/div occupancy counter nonzero
MdDone  output  1  registered one-cycle pulse when the counter reaches 0

Behaviour:
- State: md_cnt[CNT_W-1:0] and the MdDone flop. No other storage.
- rst low: md_cnt=0, MdDone=0, immediately. All outputs are 0 while rst is low, irrespective of the other inputs.
- Counter update on posedge clk:
  - MdStartE=1: md_cnt loads DIV_CYCLES if MdIsDivE=1, else MULT_CYCLES. Reload takes priority even if md_cnt is nonzero (protocol violation; restart the count).
  - Otherwise, if md_cnt!=0: md_cnt decrements by 1.
- MdBusy = (md_cnt!=0), combinational from state.
- MdDone=1 for exactly the one cycle after md_cnt goes from 1 to 0, when there is no simultaneous reload.
- ForwardAE:
  - 10 if RsE!=0 && RegWriteM && RsE==WriteRegM.
  - else 01 if RsE!=0 && RegWriteW && RsE==WriteRegW.
  - else 00.
  - M has priority over W.
- ForwardBE: same as ForwardAE, using RtE.
- ForwardAD = RsD!=0 && RegWriteM && RsD==WriteRegM. ForwardBD: same, using RtD.
- Register 0 is never forwarded.
- lwstall = MemToRegE && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && ((RegWriteE && (WriteRegE==RsD || WriteRegE==RtD)) || (MemToRegM && (WriteRegM==RsD || WriteRegM==RtD))).
- mdstall = (HiLoReadD || MdIssueD) && (MdBusy || MdStartE).
  - The MdStartE term covers the cycle before the counter loads.
- StallF = StallD = FlushE = lwstall | branchstall | mdstall. Combinational, zero-latency.
- An mdstall holds decode until the cycle in which md_cnt==0 and MdStartE==0; the stall drops in that same cycle.
- Multiple simultaneous stall causes OR together and produce a single bubble per stalled cycle.

Test Plan:
- Reset: drive rst=0 mid-divide with md_cnt=17 -> MdBusy=0, StallF=0, all Forward*=0 immediately; after release md_cnt stays 0.
- Forwarding: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> ForwardAE=10. Change WriteRegM to 6 -> ForwardAE=01. Set RsE=0 -> ForwardAE=00.
- Load-use: MemToRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle. With RtE=9 -> all stall outputs 0.
- Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall cycle. Next cycle WriteRegM=3, MemToRegM=0 -> no stall, ForwardAD=1.
- Mult/div: pulse MdStartE=1, MdIsDivE=1 (defaults), hold HiLoReadD=1 -> stall for 33 cycles (start cycle + 32 busy). MdDone pulses on the cycle after md_cnt reaches 0, the same cycle the stall drops. Repeat with MdIsDivE=0 -> 5 stall cycles.
- Back-to-back issue: MdIssueD=1 while MdBusy -> held until the counter expires. Then MdStartE reloads MULT_CYCLES; verify no MdDone pulse on the reload edge.
